fetch_unit: RTL

Sequential SEQ-side fetch stage. It is the consumer of the next-PC value that the PC-update logic computes.
- Holds the architectural PC register and loads it via a valid/ready handshake.
- Reads instruction bytes from a 64-bit-wide instruction memory port in one or two beats.
- Decodes the Y86-64 instruction fields icode, ifun, rA, rB, valC and valP, plus a status code, and presents them downstream with a valid/ready handshake.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/fetch_decode.sv | 40 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, fetch states and decode helpers
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [2:0] {
      F0     = 3'd0,
      F1     = 3'd1,
      OUT    = 3'd2,
      WAITPC = 3'd3,
      HALTED = 3'd4
   } fetch_state_t;

   // Instruction length in bytes; 0 marks an invalid icode.
   function automatic logic [3:0] instr_len(input logic [3:0] icode);
      case (icode)
         IHALT, INOP, IRET:               return 4'd1;
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    return 4'd2;
         IJXX, ICALL:                     return 4'd9;
         IIRMOVQ, IRMMOVQ, IMRMOVQ:       return 4'd10;
         default:                         return 4'd0;
      endcase
   endfunction

   // True when byte 1 of the instruction carries the rA/rB register pair.
   function automatic logic has_regids(input logic [3:0] icode);
      case (icode)
         IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
         IOPQ, IPUSHQ, IPOPQ:             return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - combinational Y86-64 instruction field decoder
module fetch_decode
   import y86_pkg::*;
(
   input  logic [79:0] ibuf,
   input  logic [63:0] pc,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        need_beat2,
   output logic        invalid
);

   logic [3:0] len;

   // Split the byte stream into fields; invalid opcodes are treated as 1 byte long.
   always_comb begin
      icode      = ibuf[7:4];
      ifun       = ibuf[3:0];
      len        = instr_len(ibuf[7:4]);
      invalid    = (len == 4'd0);
      need_beat2 = (len > 4'd8);
      rA         = RNONE;
      rB         = RNONE;
      if (has_regids(ibuf[7:4])) begin
         rA = ibuf[15:12];
         rB = ibuf[11:8];
      end
      case (ibuf[7:4])
         IIRMOVQ, IRMMOVQ, IMRMOVQ: valC = ibuf[79:16];
         IJXX, ICALL:               valC = ibuf[71:8];
         default:                   valC = 64'd0;
      endcase
      valP = pc + {60'd0, (invalid ? 4'd1 : len)};
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SEQ fetch stage: PC register, 1/2-beat imem read, decode
module fetch_unit
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] next_pc,
   input  logic        pc_valid,
   output logic        pc_ready,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [63:0] imem_rdata,
   input  logic        imem_err,
   output logic [63:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [2:0]  stat
);

   fetch_state_t state, state_nxt;

   logic [63:0] lo_q;
   logic [79:0] dec_buf;
   logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
   logic [63:0] d_valc, d_valp;
   logic        d_need_beat2, d_invalid;
   logic [2:0]  d_stat;
   logic        f0_done;
   logic        capture;

   // Beat 1 decodes straight from the bus; beat 2 appends its low bytes to the held first beat.
   always_comb begin
      dec_buf = {16'h0000, imem_rdata};
      if (state == F1) begin
         dec_buf = {imem_rdata[15:0], lo_q};
      end
   end

   fetch_decode u_decode (
      .ibuf       (dec_buf),
      .pc         (pc),
      .icode      (d_icode),
      .ifun       (d_ifun),
      .rA         (d_ra),
      .rB         (d_rb),
      .valC       (d_valc),
      .valP       (d_valp),
      .need_beat2 (d_need_beat2),
      .invalid    (d_invalid)
   );

   // Status priority: address error, then bad opcode, then halt.
   always_comb begin
      if (imem_err)              d_stat = STAT_ADR;
      else if (d_invalid)        d_stat = STAT_INS;
      else if (d_icode == IHALT) d_stat = STAT_HLT;
      else                       d_stat = STAT_AOK;
   end

   assign f0_done = imem_err || d_invalid || !d_need_beat2;
   assign capture = imem_ack && (((state == F0) && f0_done) || (state == F1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= F0;
      else        state <= state_nxt;
   end

   // Next-state logic; acks outside F0/F1 fall through untouched.
   always_comb begin
      state_nxt = state;
      case (state)
         F0:      if (imem_ack) state_nxt = f0_done ? OUT : F1;
         F1:      if (imem_ack) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = (stat == STAT_AOK) ? WAITPC : HALTED;
         WAITPC:  if (pc_valid) state_nxt = F0;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = F0;
      endcase
   end

   // Handshake outputs; the request is gated by reset so it drops the moment reset asserts.
   always_comb begin
      imem_req  = rst_n && ((state == F0) || (state == F1));
      imem_addr = (state == F1) ? (pc + 64'd8) : pc;
      out_valid = (state == OUT);
      pc_ready  = (state == WAITPC);
   end

   // PC, first-beat buffer and registered decode results held stable through OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         lo_q  <= 64'd0;
         icode <= 4'd0;
         ifun  <= 4'd0;
         rA    <= RNONE;
         rB    <= RNONE;
         valC  <= 64'd0;
         valP  <= 64'd0;
         stat  <= STAT_AOK;
      end else begin
         if ((state == WAITPC) && pc_valid) begin
            pc <= next_pc;
         end
         if ((state == F0) && imem_ack) begin
            lo_q <= imem_rdata;
         end
         if (capture) begin
            icode <= d_icode;
            ifun  <= d_ifun;
            rA    <= d_ra;
            rB    <= d_rb;
            valC  <= d_valc;
            valP  <= d_valp;
            stat  <= d_stat;
         end
      end
   end

endmodule
